// File: rtl/axi_nport_arbiter_pkg.sv
// Shared definitions for the N-port AXI master multiplexer: AXI encodings,
// channel FSM state types and the grant-width helper.
package axi_nport_arbiter_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    // Ceiling log2 with a floor of 1 so a 2-port grant index is still 1 bit wide.
    function automatic int unsigned f_log2(input int unsigned v);
        f_log2 = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) f_log2 = i + 1;
        end
    endfunction

endpackage

// File: rtl/axi_nport_arbiter_rr_arbiter.sv
// Request arbiter: round-robin starting at i_ptr, or fixed priority with
// port 0 highest. Returns both a one-hot grant and its binary index.
module rr_arbiter
    import axi_nport_arbiter_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter bit          RR_MODE = 1'b1,
    localparam int unsigned GW     = f_log2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [GW-1:0] o_idx
);

    logic          w_found;
    int unsigned   w_pos;
    logic [GW-1:0] w_sel;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = (RR_MODE ? 32'(i_ptr) : 32'd0) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            w_sel = GW'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                w_found      = 1'b1;
                o_gnt[w_sel] = 1'b1;
                o_idx        = w_sel;
            end
        end
    end

endmodule

// File: rtl/axi_nport_arbiter.sv
// N-port AXI4 master multiplexer: independent read and write arbitration,
// one burst outstanding per direction, downstream ID carries the granted port.
module axi_nport_arbiter
    import axi_nport_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter bit          RR_MODE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         s_arvalid,
    input  logic [N_PORTS*ADDR_W-1:0]  s_araddr,
    input  logic [N_PORTS*8-1:0]       s_arlen,
    input  logic [N_PORTS*3-1:0]       s_arsize,
    input  logic [N_PORTS*2-1:0]       s_arburst,
    output logic [N_PORTS-1:0]         s_arready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rlast,
    output logic [N_PORTS-1:0]         s_rvalid,
    input  logic [N_PORTS-1:0]         s_rready,
    input  logic [N_PORTS-1:0]         s_awvalid,
    input  logic [N_PORTS*ADDR_W-1:0]  s_awaddr,
    input  logic [N_PORTS*8-1:0]       s_awlen,
    input  logic [N_PORTS*3-1:0]       s_awsize,
    input  logic [N_PORTS*2-1:0]       s_awburst,
    output logic [N_PORTS-1:0]         s_awready,
    input  logic [N_PORTS*DATA_W-1:0]  s_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0] s_wstrb,
    input  logic [N_PORTS-1:0]         s_wlast,
    input  logic [N_PORTS-1:0]         s_wvalid,
    output logic [N_PORTS-1:0]         s_wready,
    output logic [1:0]                 s_bresp,
    output logic [N_PORTS-1:0]         s_bvalid,
    input  logic [N_PORTS-1:0]         s_bready,
    output logic [ID_W-1:0]            m_arid,
    output logic [ADDR_W-1:0]          m_araddr,
    output logic [7:0]                 m_arlen,
    output logic [2:0]                 m_arsize,
    output logic [1:0]                 m_arburst,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [ID_W-1:0]            m_rid,
    input  logic [DATA_W-1:0]          m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rlast,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    output logic [ID_W-1:0]            m_awid,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [7:0]                 m_awlen,
    output logic [2:0]                 m_awsize,
    output logic [1:0]                 m_awburst,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_wlast,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    input  logic [ID_W-1:0]            m_bid,
    input  logic [1:0]                 m_bresp,
    input  logic                       m_bvalid,
    output logic                       m_bready
);

    localparam int unsigned GW = f_log2(N_PORTS);
    localparam int unsigned SW = DATA_W / 8;

    rd_state_e r_rs, w_rs_next;
    wr_state_e r_ws, w_ws_next;

    logic [GW-1:0]      r_rg, r_wg, r_rptr, r_wptr;
    logic [GW-1:0]      w_ar_idx, w_aw_idx;
    logic [N_PORTS-1:0] w_ar_gnt, w_aw_gnt;
    logic               w_r_done, w_b_done;
    logic               w_unused_ids;

    rr_arbiter #(.N(N_PORTS), .RR_MODE(RR_MODE)) u_ar_arb (
        .i_req(s_arvalid), .i_ptr(r_rptr), .o_gnt(w_ar_gnt), .o_idx(w_ar_idx)
    );

    rr_arbiter #(.N(N_PORTS), .RR_MODE(RR_MODE)) u_aw_arb (
        .i_req(s_awvalid), .i_ptr(r_wptr), .o_gnt(w_aw_gnt), .o_idx(w_aw_idx)
    );

    // Routing follows the held grant, so returned IDs are not needed.
    assign w_unused_ids = ^{m_rid, m_bid};

    assign m_arid    = ID_W'(r_rg);
    assign m_araddr  = s_araddr[32'(r_rg)*ADDR_W +: ADDR_W];
    assign m_arlen   = s_arlen[32'(r_rg)*8 +: 8];
    assign m_arsize  = s_arsize[32'(r_rg)*3 +: 3];
    assign m_arburst = s_arburst[32'(r_rg)*2 +: 2];
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;

    assign m_awid    = ID_W'(r_wg);
    assign m_awaddr  = s_awaddr[32'(r_wg)*ADDR_W +: ADDR_W];
    assign m_awlen   = s_awlen[32'(r_wg)*8 +: 8];
    assign m_awsize  = s_awsize[32'(r_wg)*3 +: 3];
    assign m_awburst = s_awburst[32'(r_wg)*2 +: 2];
    assign m_wdata   = s_wdata[32'(r_wg)*DATA_W +: DATA_W];
    assign m_wstrb   = s_wstrb[32'(r_wg)*SW +: SW];
    assign m_wlast   = s_wlast[r_wg];
    assign s_bresp   = m_bresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs   <= R_IDLE;
            r_rg   <= '0;
            r_rptr <= '0;
        end else begin
            r_rs <= w_rs_next;
            if (r_rs == R_IDLE && |w_ar_gnt) r_rg <= w_ar_idx;
            if (w_r_done && RR_MODE) r_rptr <= (r_rg == GW'(N_PORTS - 1)) ? '0 : r_rg + 1'b1;
        end
    end

    always_comb begin
        w_rs_next = r_rs;
        s_arready = '0;
        s_rvalid  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        w_r_done  = 1'b0;
        case (r_rs)
            R_IDLE: if (|w_ar_gnt) w_rs_next = R_ADDR;
            R_ADDR: begin
                m_arvalid       = s_arvalid[r_rg];
                s_arready[r_rg] = m_arready;
                if (s_arvalid[r_rg] && m_arready) w_rs_next = R_DATA;
            end
            R_DATA: begin
                s_rvalid[r_rg] = m_rvalid;
                m_rready       = s_rready[r_rg];
                if (m_rvalid && s_rready[r_rg] && m_rlast) begin
                    w_rs_next = R_IDLE;
                    w_r_done  = 1'b1;
                end
            end
            default: w_rs_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ws   <= W_IDLE;
            r_wg   <= '0;
            r_wptr <= '0;
        end else begin
            r_ws <= w_ws_next;
            if (r_ws == W_IDLE && |w_aw_gnt) r_wg <= w_aw_idx;
            if (w_b_done && RR_MODE) r_wptr <= (r_wg == GW'(N_PORTS - 1)) ? '0 : r_wg + 1'b1;
        end
    end

    always_comb begin
        w_ws_next = r_ws;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        w_b_done  = 1'b0;
        case (r_ws)
            W_IDLE: if (|w_aw_gnt) w_ws_next = W_ADDR;
            W_ADDR: begin
                m_awvalid       = s_awvalid[r_wg];
                s_awready[r_wg] = m_awready;
                if (s_awvalid[r_wg] && m_awready) w_ws_next = W_DATA;
            end
            W_DATA: begin
                m_wvalid       = s_wvalid[r_wg];
                s_wready[r_wg] = m_wready;
                if (s_wvalid[r_wg] && m_wready && s_wlast[r_wg]) w_ws_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid[r_wg] = m_bvalid;
                m_bready       = s_bready[r_wg];
                if (m_bvalid && s_bready[r_wg]) begin
                    w_ws_next = W_IDLE;
                    w_b_done  = 1'b1;
                end
            end
            default: w_ws_next = W_IDLE;
        endcase
    end

    // A granted request must stay asserted until its address handshake.
    a_ar_held: assert property (@(posedge clk) disable iff (rst) (r_rs == R_ADDR) |-> s_arvalid[r_rg]);
    a_aw_held: assert property (@(posedge clk) disable iff (rst) (r_ws == W_ADDR) |-> s_awvalid[r_wg]);

endmodule

// File: tb/tb_axi_nport_arbiter.sv
// Directed bench: a 3-port round-robin instance and a 2-port fixed-priority
// instance, with the downstream slave driven by hand from each scenario task.
module tb_axi_nport_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 3-port round-robin instance
    logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [95:0] s_araddr, s_awaddr, s_wdata;
    logic [23:0] s_arlen, s_awlen;
    logic [8:0]  s_arsize, s_awsize;
    logic [5:0]  s_arburst, s_awburst;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        s_rlast;
    logic [2:0]  s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [11:0] s_wstrb;
    logic [3:0]  m_arid, m_rid, m_awid, m_bid, m_wstrb;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    axi_nport_arbiter #(.N_PORTS(3), .ADDR_W(32), .DATA_W(32), .ID_W(4), .RR_MODE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    // 2-port fixed-priority instance, read side only exercised
    logic [1:0]  f_s_arvalid, f_s_arready, f_s_rvalid, f_s_awready, f_s_wready, f_s_bvalid;
    logic [31:0] f_s_rdata, f_m_araddr, f_m_awaddr, f_m_wdata;
    logic [1:0]  f_s_rresp, f_s_bresp, f_m_arburst, f_m_awburst;
    logic        f_s_rlast, f_m_arvalid, f_m_arready, f_m_rvalid, f_m_rlast, f_m_rready;
    logic        f_m_awvalid, f_m_wlast, f_m_wvalid, f_m_bready;
    logic [3:0]  f_m_arid, f_m_awid, f_m_wstrb;
    logic [7:0]  f_m_arlen, f_m_awlen;
    logic [2:0]  f_m_arsize, f_m_awsize;

    axi_nport_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .s_arvalid(f_s_arvalid), .s_araddr(64'h0), .s_arlen(16'h0), .s_arsize(6'h0),
        .s_arburst(4'h0), .s_arready(f_s_arready), .s_rdata(f_s_rdata), .s_rresp(f_s_rresp),
        .s_rlast(f_s_rlast), .s_rvalid(f_s_rvalid), .s_rready(2'b11),
        .s_awvalid(2'b00), .s_awaddr(64'h0), .s_awlen(16'h0), .s_awsize(6'h0),
        .s_awburst(4'h0), .s_awready(f_s_awready), .s_wdata(64'h0), .s_wstrb(8'h0),
        .s_wlast(2'b00), .s_wvalid(2'b00), .s_wready(f_s_wready), .s_bresp(f_s_bresp),
        .s_bvalid(f_s_bvalid), .s_bready(2'b00),
        .m_arid(f_m_arid), .m_araddr(f_m_araddr), .m_arlen(f_m_arlen), .m_arsize(f_m_arsize),
        .m_arburst(f_m_arburst), .m_arvalid(f_m_arvalid), .m_arready(f_m_arready),
        .m_rid(4'h0), .m_rdata(32'h0), .m_rresp(2'b00), .m_rlast(f_m_rlast),
        .m_rvalid(f_m_rvalid), .m_rready(f_m_rready),
        .m_awid(f_m_awid), .m_awaddr(f_m_awaddr), .m_awlen(f_m_awlen), .m_awsize(f_m_awsize),
        .m_awburst(f_m_awburst), .m_awvalid(f_m_awvalid), .m_awready(1'b0),
        .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_wlast(f_m_wlast), .m_wvalid(f_m_wvalid),
        .m_wready(1'b0), .m_bid(4'h0), .m_bresp(2'b00), .m_bvalid(1'b0),
        .m_bready(f_m_bready)
    );

    // Waits (bounded) for m_arvalid, records what is presented, then accepts it.
    task automatic a_ar(output logic [3:0] id, output logic [31:0] addr,
                        output logic [2:0] rdy, output bit ok);
        ok = 1'b0; id = '0; addr = '0; rdy = '0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (m_arvalid) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (ok) begin
            id = m_arid; addr = m_araddr;
            m_arready = 1'b1;
            #1 rdy = s_arready;
            @(posedge clk); #1;
            m_arready = 1'b0;
        end
    endtask

    // Returns a read burst of n beats; rv captures s_rvalid on the first beat.
    task automatic a_r(input int n, input logic [31:0] base, output logic [2:0] rv);
        rv = '0;
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1; m_rdata = base + 32'(i); m_rlast = (i == n - 1);
            #1;
            if (i == 0) rv = s_rvalid;
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid, m_arvalid, m_rready,
             m_awvalid, m_wvalid, m_bready} !== 20'h0) begin
            errors++; $display("FAIL reset_outputs_a: got %h required 0", {s_arready, s_rvalid,
                s_awready, s_wready, s_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({f_s_arready, f_s_rvalid, f_s_awready, f_s_wready, f_s_bvalid, f_m_arvalid,
             f_m_rready, f_m_awvalid, f_m_wvalid, f_m_bready} !== 15'h0) begin
            errors++; $display("FAIL reset_outputs_fp: got %h required 0", {f_s_arready, f_s_rvalid,
                f_s_awready, f_s_wready, f_s_bvalid, f_m_arvalid, f_m_rready, f_m_awvalid, f_m_wvalid, f_m_bready});
        end
    endtask

    task automatic test_rr_read;
        logic [3:0] id; logic [31:0] addr; logic [2:0] rdy, rv; bit ok;
        s_araddr = {32'h3000, 32'h2000, 32'h1000};
        s_arvalid = 3'b011;
        a_ar(id, addr, rdy, ok);
        checks++;
        if (!ok || id !== 4'd0 || addr !== 32'h1000 || rdy !== 3'b001) begin
            errors++; $display("FAIL rr_first_grant: ok=%0d id=%0d addr=%h rdy=%b required 1/0/1000/001", ok, id, addr, rdy);
        end
        a_r(1, 32'hA0, rv);
        checks++;
        if (rv !== 3'b001) begin errors++; $display("FAIL rr_first_rvalid: got %b required 001", rv); end
        checks++;
        if (m_arvalid !== 1'b0) begin errors++; $display("FAIL idle_arvalid: got %b required 0", m_arvalid); end
        a_ar(id, addr, rdy, ok);
        checks++;
        if (!ok || id !== 4'd1 || addr !== 32'h2000 || rdy !== 3'b010) begin
            errors++; $display("FAIL rr_second_grant: ok=%0d id=%0d addr=%h rdy=%b required 1/1/2000/010", ok, id, addr, rdy);
        end
        a_r(1, 32'hB0, rv);
        checks++;
        if (rv !== 3'b010) begin errors++; $display("FAIL rr_second_rvalid: got %b required 010", rv); end
        s_arvalid = 3'b000;
    endtask

    task automatic test_reset_mid_burst;
        logic [3:0] id; logic [31:0] addr; logic [2:0] rdy; bit ok;
        s_arlen = 24'h000003;
        s_arvalid = 3'b001;
        a_ar(id, addr, rdy, ok);
        s_arvalid = 3'b000;
        m_rvalid = 1'b1; m_rdata = 32'h1; m_rlast = 1'b0;
        @(posedge clk); #1;
        m_rdata = 32'h2;
        #1;
        checks++;
        if (!ok || s_rvalid !== 3'b001 || m_rready !== 1'b1) begin
            errors++; $display("FAIL midburst_beat2: ok=%0d rvalid=%b rready=%b required 1/001/1", ok, s_rvalid, m_rready);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid, m_arvalid, m_rready,
             m_awvalid, m_wvalid, m_bready} !== 20'h0) begin
            errors++; $display("FAIL async_reset_drop: got %h required 0", {s_arready, s_rvalid,
                s_awready, s_wready, s_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
        end
        m_rvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        s_arlen = '0;
    endtask

    task automatic test_rr_wrap;
        logic [3:0] id; logic [31:0] addr; logic [2:0] rdy, rv; bit ok;
        logic [3:0] exp_id;
        s_arvalid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_id = 4'(k % 3);
            a_ar(id, addr, rdy, ok);
            checks++;
            if (!ok || id !== exp_id || addr !== 32'h1000 * (32'(exp_id) + 1)) begin
                errors++; $display("FAIL rr_wrap_%0d: ok=%0d id=%0d addr=%h required id %0d", k, ok, id, addr, exp_id);
            end
            a_r(1, 32'hC0, rv);
        end
        s_arvalid = 3'b000;
    endtask

    task automatic test_write_burst;
        logic [127:0] got; logic [3:0] lasts; bit strb_ok, found; int k;
        got = '0; lasts = '0; strb_ok = 1'b1; found = 1'b0; k = 0;
        s_awaddr = {32'h0, 32'h4000, 32'h0};
        s_awlen = 24'h000300;
        s_wstrb = 12'hFFF;
        s_wvalid = 3'b010; s_wdata = {32'h0, 32'h11, 32'h0}; s_wlast = 3'b000;
        #1;
        checks++;
        if (s_wready !== 3'b000 || m_wvalid !== 1'b0) begin
            errors++; $display("FAIL w_before_aw_idle: wready=%b m_wvalid=%b required 000/0", s_wready, m_wvalid);
        end
        s_awvalid = 3'b010;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_awvalid) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!found || m_awid !== 4'd1 || m_awaddr !== 32'h4000 || m_awlen !== 8'd3 || s_wready !== 3'b000) begin
            errors++; $display("FAIL aw_grant: found=%0d id=%0d addr=%h len=%0d wready=%b required 1/1/4000/3/000",
                found, m_awid, m_awaddr, m_awlen, s_wready);
        end
        m_awready = 1'b1;
        @(posedge clk); #1;
        m_awready = 1'b0; s_awvalid = 3'b000;
        for (int c = 0; c < 20 && k < 4; c++) begin
            s_wdata[32 +: 32] = 32'h11 * 32'(k + 1);
            s_wlast = (k == 3) ? 3'b010 : 3'b000;
            m_wready = c[0];
            #1;
            if (m_wvalid && m_wready) begin
                got[k*32 +: 32] = m_wdata;
                lasts[k] = m_wlast;
                if (m_wstrb !== 4'hF) strb_ok = 1'b0;
                k++;
            end
            @(posedge clk); #1;
        end
        s_wvalid = 3'b000; s_wlast = 3'b000; m_wready = 1'b0;
        checks++;
        if (k != 4 || got !== {32'h44, 32'h33, 32'h22, 32'h11} || lasts !== 4'b1000 || !strb_ok) begin
            errors++; $display("FAIL w_beats: n=%0d data=%h lasts=%b strb_ok=%0d required 4/44..11/1000/1", k, got, lasts, strb_ok);
        end
        #1;
        checks++;
        if (s_bvalid !== 3'b000 || m_bready !== 1'b1) begin
            errors++; $display("FAIL b_before_mbvalid: bvalid=%b bready=%b required 000/1", s_bvalid, m_bready);
        end
        m_bvalid = 1'b1; m_bresp = 2'b10;
        #1;
        checks++;
        if (s_bvalid !== 3'b010 || s_bresp !== 2'b10) begin
            errors++; $display("FAIL b_route: bvalid=%b bresp=%b required 010/10", s_bvalid, s_bresp);
        end
        @(posedge clk); #1;
        m_bvalid = 1'b0; m_bresp = 2'b00;
        checks++;
        if (m_bready !== 1'b0) begin errors++; $display("FAIL w_back_idle: bready=%b required 0", m_bready); end
    endtask

    task automatic test_concurrent;
        s_araddr = {32'h0, 32'h0, 32'h6000}; s_arvalid = 3'b001;
        s_awaddr = {32'h0, 32'h7000, 32'h0}; s_awlen = '0; s_awvalid = 3'b010;
        s_wdata = {32'h0, 32'h55, 32'h0}; s_wlast = 3'b010; s_wvalid = 3'b010;
        @(posedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b1 || m_awvalid !== 1'b1 || m_arid !== 4'd0 || m_awid !== 4'd1) begin
            errors++; $display("FAIL conc_addr: arv=%b awv=%b arid=%0d awid=%0d required 1/1/0/1", m_arvalid, m_awvalid, m_arid, m_awid);
        end
        m_arready = 1'b1; m_awready = 1'b1;
        @(posedge clk); #1;
        m_arready = 1'b0; m_awready = 1'b0; s_arvalid = 3'b000; s_awvalid = 3'b000;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hBEEF; m_wready = 1'b1;
        #1;
        checks++;
        if (s_rvalid !== 3'b001 || s_wready !== 3'b010 || s_bvalid !== 3'b000 || s_rdata !== 32'hBEEF || m_wdata !== 32'h55) begin
            errors++; $display("FAIL conc_data: rvalid=%b wready=%b bvalid=%b rdata=%h wdata=%h required 001/010/000/beef/55",
                s_rvalid, s_wready, s_bvalid, s_rdata, m_wdata);
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0; s_wvalid = 3'b000; s_wlast = 3'b000; m_wready = 1'b0;
        m_bvalid = 1'b1;
        #1;
        checks++;
        if (s_bvalid !== 3'b010 || s_rvalid !== 3'b000) begin
            errors++; $display("FAIL conc_resp: bvalid=%b rvalid=%b required 010/000", s_bvalid, s_rvalid);
        end
        @(posedge clk); #1;
        m_bvalid = 1'b0;
        checks++;
        if (m_bready !== 1'b0 || m_rready !== 1'b0) begin
            errors++; $display("FAIL conc_idle: bready=%b rready=%b required 0/0", m_bready, m_rready);
        end
    endtask

    task automatic test_fixed_priority;
        bit found; logic [3:0] id; logic [1:0] rdy;
        f_s_arvalid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) f_s_arvalid = 2'b10;
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                if (f_m_arvalid) found = 1'b1;
                else begin @(posedge clk); #1; end
            end
            id = f_m_arid;
            f_m_arready = 1'b1;
            #1 rdy = f_s_arready;
            checks++;
            if (b < 3 && (!found || id !== 4'd0 || rdy !== 2'b01)) begin
                errors++; $display("FAIL fp_port0_wins_%0d: found=%0d id=%0d rdy=%b required 1/0/01", b, found, id, rdy);
            end else if (b == 3 && (!found || id !== 4'd1 || rdy !== 2'b10)) begin
                errors++; $display("FAIL fp_port1_after_drop: found=%0d id=%0d rdy=%b required 1/1/10", found, id, rdy);
            end
            @(posedge clk); #1;
            f_m_arready = 1'b0;
            f_m_rvalid = 1'b1; f_m_rlast = 1'b1;
            @(posedge clk); #1;
            f_m_rvalid = 1'b0; f_m_rlast = 1'b0;
        end
        f_s_arvalid = 2'b00;
    endtask

    initial begin
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready = 3'b111; s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
        s_bready = 3'b111;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        f_s_arvalid = '0; f_m_arready = 1'b0; f_m_rvalid = 1'b0; f_m_rlast = 1'b0;

        test_reset;
        test_rr_read;
        test_reset_mid_burst;
        test_rr_wrap;
        test_write_burst;
        test_concurrent;
        test_fixed_priority;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
